ddr_port_arbiter: RTL and testbench

DDR_PORT_ARBITER -- requirements
Module: ddr_port_arbiter

---
 rtl/ddr_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_ddr_port_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_port_arbiter.sv
// Multi-channel front-end for a DDR controller core: picks one requester (fixed priority
// or round-robin), latches its command, supports ownership locks and interleaves refresh.
module ddr_port_arbiter #(
    parameter int NCH  = 4,
    parameter int AW   = 26,
    parameter int DW   = 32,
    parameter int MODE = 0,
    localparam int OW  = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int BW  = DW / 8
) (
    input  logic              CLK_n,
    input  logic              RST,
    input  logic              refresh_strobe,
    input  logic [NCH-1:0]    ch_req,
    input  logic [NCH-1:0]    ch_we,
    input  logic [NCH*BW-1:0] ch_we_array,
    input  logic [NCH*AW-1:0] ch_address,
    input  logic [NCH*DW-1:0] ch_datain,
    input  logic [NCH-1:0]    ch_algn,
    output logic [NCH-1:0]    ch_ack,
    output logic [NCH-1:0]    ch_algn_ack,
    output logic              core_req,
    input  logic              core_ack,
    output logic [AW-1:0]     core_address,
    output logic              core_we,
    output logic [BW-1:0]     core_we_array,
    output logic [DW-1:0]     core_datain,
    output logic              core_refresh,
    input  logic              core_refresh_done,
    output logic [OW-1:0]     owner,
    output logic [1:0]        state_dbg
);

    // Handshakes: core_req is held with stable command fields until the cycle core_ack is
    // seen; core_refresh is held until core_refresh_done; ch_ack pulses on the accept cycle.
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, LOCKED = 2'd2, REFRESH = 2'd3} state_t;

    state_t          state, state_nxt;
    logic [OW-1:0]   rr_ptr, rr_ptr_nxt, owner_nxt;
    logic            lock_q, lock_nxt;
    logic            refresh_pending, pending_nxt;
    logic [AW-1:0]   addr_nxt;
    logic            we_nxt;
    logic [BW-1:0]   be_nxt;
    logic            latch;
    logic [OW-1:0]   latch_ch;
    logic [OW-1:0]   winner;
    logic [OW-1:0]   idx;
    logic            found;

    // Winner search: fixed mode scans from 0; round-robin scans from the slot after the last owner.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NCH; i++) begin
            if (MODE == 1) idx = OW'((int'(rr_ptr) + 1 + i) % NCH);
            else           idx = OW'(i);
            if (!found && ch_req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        rr_ptr_nxt  = rr_ptr;
        lock_nxt    = lock_q;
        addr_nxt    = core_address;
        we_nxt      = core_we;
        be_nxt      = core_we_array;
        pending_nxt = refresh_pending | refresh_strobe;
        latch       = 1'b0;
        latch_ch    = owner;
        case (state)
            IDLE: begin
                if (refresh_pending || refresh_strobe) begin
                    state_nxt = REFRESH;
                end else if (found) begin
                    latch      = 1'b1;
                    latch_ch   = winner;
                    rr_ptr_nxt = winner;
                    state_nxt  = ISSUE;
                end
            end
            ISSUE: begin
                if (core_ack) begin
                    lock_nxt  = ch_algn[owner];
                    state_nxt = ch_algn[owner] ? LOCKED : IDLE;
                end
            end
            LOCKED: begin
                if (!ch_algn[owner]) begin
                    lock_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else if (ch_req[owner]) begin
                    latch     = 1'b1;
                    latch_ch  = owner;
                    state_nxt = ISSUE;
                end
            end
            REFRESH: begin
                if (core_refresh_done) begin
                    // A strobe landing on the done cycle is a new request, not the one just served.
                    pending_nxt = refresh_strobe;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (latch) begin
            owner_nxt = latch_ch;
            addr_nxt  = ch_address[int'(latch_ch)*AW +: AW];
            we_nxt    = ch_we[latch_ch];
            be_nxt    = ch_we_array[int'(latch_ch)*BW +: BW];
        end
    end

    always_ff @(posedge CLK_n or posedge RST) begin
        if (RST) begin
            state           <= IDLE;
            owner           <= '0;
            rr_ptr          <= OW'(NCH - 1);
            lock_q          <= 1'b0;
            refresh_pending <= 1'b0;
            core_address    <= '0;
            core_we         <= 1'b0;
            core_we_array   <= '0;
        end else begin
            state           <= state_nxt;
            owner           <= owner_nxt;
            rr_ptr          <= rr_ptr_nxt;
            lock_q          <= lock_nxt;
            refresh_pending <= pending_nxt;
            core_address    <= addr_nxt;
            core_we         <= we_nxt;
            core_we_array   <= be_nxt;
        end
    end

    always_comb begin
        ch_ack      = '0;
        ch_algn_ack = '0;
        if (state == ISSUE && core_ack) ch_ack[owner] = 1'b1;
        if (lock_q) ch_algn_ack[owner] = 1'b1;
    end

    assign core_req     = (state == ISSUE);
    assign core_refresh = (state == REFRESH);
    assign core_datain  = ch_datain[int'(owner)*DW +: DW];
    assign state_dbg    = state;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Bench for ddr_port_arbiter: one fixed-priority and one round-robin instance driven
// side by side, checked against a transaction-level model of who should win and what.
module tb_ddr_port_arbiter;
    localparam int NCH = 4;
    localparam int AW  = 26;
    localparam int DW  = 32;
    localparam int BW  = DW / 8;
    localparam int OW  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              refresh_strobe    [2];
    logic [NCH-1:0]    ch_req            [2];
    logic [NCH-1:0]    ch_we             [2];
    logic [NCH*BW-1:0] ch_we_array       [2];
    logic [NCH*AW-1:0] ch_address        [2];
    logic [NCH*DW-1:0] ch_datain         [2];
    logic [NCH-1:0]    ch_algn           [2];
    logic              core_ack          [2];
    logic              core_refresh_done [2];
    logic [NCH-1:0]    ch_ack            [2];
    logic [NCH-1:0]    ch_algn_ack       [2];
    logic              core_req          [2];
    logic [AW-1:0]     core_address      [2];
    logic              core_we           [2];
    logic [BW-1:0]     core_we_array     [2];
    logic [DW-1:0]     core_datain       [2];
    logic              core_refresh      [2];
    logic [OW-1:0]     owner             [2];
    logic [1:0]        state_dbg         [2];

    ddr_port_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .MODE(0)) u_fixed (
        .CLK_n(clk), .RST(rst), .refresh_strobe(refresh_strobe[0]),
        .ch_req(ch_req[0]), .ch_we(ch_we[0]), .ch_we_array(ch_we_array[0]),
        .ch_address(ch_address[0]), .ch_datain(ch_datain[0]), .ch_algn(ch_algn[0]),
        .ch_ack(ch_ack[0]), .ch_algn_ack(ch_algn_ack[0]), .core_req(core_req[0]),
        .core_ack(core_ack[0]), .core_address(core_address[0]), .core_we(core_we[0]),
        .core_we_array(core_we_array[0]), .core_datain(core_datain[0]),
        .core_refresh(core_refresh[0]), .core_refresh_done(core_refresh_done[0]),
        .owner(owner[0]), .state_dbg(state_dbg[0])
    );

    ddr_port_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .MODE(1)) u_rr (
        .CLK_n(clk), .RST(rst), .refresh_strobe(refresh_strobe[1]),
        .ch_req(ch_req[1]), .ch_we(ch_we[1]), .ch_we_array(ch_we_array[1]),
        .ch_address(ch_address[1]), .ch_datain(ch_datain[1]), .ch_algn(ch_algn[1]),
        .ch_ack(ch_ack[1]), .ch_algn_ack(ch_algn_ack[1]), .core_req(core_req[1]),
        .core_ack(core_ack[1]), .core_address(core_address[1]), .core_we(core_we[1]),
        .core_we_array(core_we_array[1]), .core_datain(core_datain[1]),
        .core_refresh(core_refresh[1]), .core_refresh_done(core_refresh_done[1]),
        .owner(owner[1]), .state_dbg(state_dbg[1])
    );

    // Model state: per-channel command contents and the last granted channel per instance.
    logic [AW-1:0] m_addr [2][NCH];
    logic [DW-1:0] m_data [2][NCH];
    logic          m_we   [2][NCH];
    logic [BW-1:0] m_be   [2][NCH];
    int            last_owner [2];
    logic [OW-1:0] exp_q [$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic pack(input int m);
        for (int c = 0; c < NCH; c++) begin
            ch_address[m][c*AW +: AW]  = m_addr[m][c];
            ch_datain[m][c*DW +: DW]   = m_data[m][c];
            ch_we_array[m][c*BW +: BW] = m_be[m][c];
            ch_we[m][c]                = m_we[m][c];
        end
    endtask

    task automatic load_channels(input int m);
        for (int c = 0; c < NCH; c++) begin
            m_addr[m][c] = AW'($urandom);
            m_data[m][c] = $urandom;
            m_we[m][c]   = 1'($urandom_range(0, 1));
            m_be[m][c]   = BW'($urandom);
        end
        pack(m);
    endtask

    // Fixed mode: lowest requesting index. Round-robin: first requester after the last owner.
    function automatic int pick(input int m, input logic [NCH-1:0] mask);
        for (int k = 1; k <= NCH; k++) begin
            int c;
            c = (m == 0) ? k - 1 : (last_owner[m] + k) % NCH;
            if (mask[c]) return c;
        end
        return 0;
    endfunction

    task automatic wait_issue(input int m);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (core_req[m]) ok = 1'b1;
            else begin @(negedge clk); #1; end
        end
        if (!ok) check_eq("issue_timeout", 64'd0, 64'd1);
    endtask

    task automatic grant_and_ack(input int m, input int hold, input bit drop_early,
                                 input logic [NCH-1:0] keep, input logic [NCH-1:0] exp_lock);
        int e;
        logic [NCH-1:0] oh;
        if (exp_q.size() == 0) begin
            check_eq("exp_q_empty", 64'd1, 64'd0);
            return;
        end
        e  = int'(exp_q.pop_front());
        oh = NCH'(1) << e;
        last_owner[m] = e;
        check_eq("owner",         64'(owner[m]),         64'(e));
        check_eq("core_address",  64'(core_address[m]),  64'(m_addr[m][e]));
        check_eq("core_we",       64'(core_we[m]),       64'(m_we[m][e]));
        check_eq("core_we_array", 64'(core_we_array[m]), 64'(m_be[m][e]));
        check_eq("core_datain",   64'(core_datain[m]),   64'(m_data[m][e]));
        check_eq("algn_ack_issue", 64'(ch_algn_ack[m]),  64'(exp_lock));
        if (drop_early) ch_req[m][e] = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            m_data[m][e] = $urandom;
            pack(m);
            #1;
            check_eq("core_req_hold", 64'(core_req[m]),     64'd1);
            check_eq("addr_stable",   64'(core_address[m]), 64'(m_addr[m][e]));
            check_eq("datain_follow", 64'(core_datain[m]),  64'(m_data[m][e]));
            check_eq("no_early_ack",  64'(ch_ack[m]),       64'd0);
            check_eq("algn_ack_hold", 64'(ch_algn_ack[m]),  64'(exp_lock));
        end
        core_ack[m] = 1'b1;
        #1;
        check_eq("ch_ack_pulse", 64'(ch_ack[m]), 64'(oh));
        ch_req[m] = ch_req[m] & keep;
        @(negedge clk);
        core_ack[m] = 1'b0;
        #1;
        check_eq("core_req_drop", 64'(core_req[m]), 64'd0);
        check_eq("ch_ack_clear",  64'(ch_ack[m]),   64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NCH-1:0] keep_v;
        rst = 1'b1;
        for (int m = 0; m < 2; m++) begin
            refresh_strobe[m] = 1'b0; ch_req[m] = '0; ch_algn[m] = '0;
            core_ack[m] = 1'b0; core_refresh_done[m] = 1'b0;
            last_owner[m] = NCH - 1;
            load_channels(m);
        end
        #1;
        for (int m = 0; m < 2; m++) begin
            check_eq("rst_core_req",    64'(core_req[m]),      64'd0);
            check_eq("rst_refresh",     64'(core_refresh[m]),  64'd0);
            check_eq("rst_owner",       64'(owner[m]),         64'd0);
            check_eq("rst_ch_ack",      64'(ch_ack[m]),        64'd0);
            check_eq("rst_algn_ack",    64'(ch_algn_ack[m]),   64'd0);
            check_eq("rst_address",     64'(core_address[m]),  64'd0);
            check_eq("rst_we",          64'(core_we[m]),       64'd0);
            check_eq("rst_we_array",    64'(core_we_array[m]), 64'd0);
            check_eq("rst_state",       64'(state_dbg[m]),     64'd0);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;

        // Fixed priority: 1010 -> ch1, then ch3.
        ch_req[0] = 4'b1010;
        exp_q.push_back(OW'(1));
        @(negedge clk); #1;
        check_eq("fixed_latency", 64'(core_req[0]), 64'd1);
        grant_and_ack(0, 2, 1'b0, 4'b1000, 4'b0000);
        exp_q.push_back(OW'(3));
        wait_issue(0);
        grant_and_ack(0, 1, 1'b0, 4'b0000, 4'b0000);

        // Round-robin with all channels held: 0,1,2,3,0 from the reset pointer.
        ch_req[1] = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            exp_q.push_back(OW'(n % NCH));
            wait_issue(1);
            keep_v = (n == 4) ? 4'b0000 : 4'b1111;
            grant_and_ack(1, $urandom_range(0, 2), 1'b0, keep_v, 4'b0000);
        end

        // Random request masks, random hold times, random early withdrawal.
        for (int m = 0; m < 2; m++) begin
            for (int it = 0; it < 25; it++) begin
                logic [NCH-1:0] mask;
                load_channels(m);
                mask = NCH'($urandom_range(1, (1 << NCH) - 1));
                exp_q.push_back(OW'(pick(m, mask)));
                ch_req[m] = mask;
                @(negedge clk); #1;
                check_eq("rand_latency", 64'(core_req[m]), 64'd1);
                wait_issue(m);
                grant_and_ack(m, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 4'b0000, 4'b0000);
            end
        end

        // Refresh and ch0 together: refresh first, extra strobes merge, ack ignored.
        load_channels(0);
        ch_req[0] = 4'b0001;
        refresh_strobe[0] = 1'b1;
        @(negedge clk);
        refresh_strobe[0] = 1'b0;
        #1;
        check_eq("refresh_first", 64'(core_refresh[0]), 64'd1);
        check_eq("refresh_no_req", 64'(core_req[0]), 64'd0);
        refresh_strobe[0] = 1'b1;
        core_ack[0] = 1'b1;
        #1;
        check_eq("refresh_ack_ignored", 64'(ch_ack[0]), 64'd0);
        @(negedge clk);
        refresh_strobe[0] = 1'b0;
        core_ack[0] = 1'b0;
        #1;
        check_eq("refresh_hold", 64'(core_refresh[0]), 64'd1);
        check_eq("refresh_hold_req", 64'(core_req[0]), 64'd0);
        core_refresh_done[0] = 1'b1;
        @(negedge clk);
        core_refresh_done[0] = 1'b0;
        #1;
        check_eq("refresh_exit", 64'(core_refresh[0]), 64'd0);
        exp_q.push_back(OW'(0));
        @(negedge clk); #1;
        check_eq("after_refresh_req", 64'(core_req[0]), 64'd1);
        grant_and_ack(0, 1, 1'b0, 4'b0000, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check_eq("refresh_merged", 64'(core_refresh[0]), 64'd0);
        end

        // Strobe coincident with done leaves another refresh pending.
        refresh_strobe[0] = 1'b1;
        @(negedge clk);
        refresh_strobe[0] = 1'b0;
        #1;
        check_eq("refresh2_start", 64'(core_refresh[0]), 64'd1);
        core_refresh_done[0] = 1'b1;
        refresh_strobe[0] = 1'b1;
        @(negedge clk);
        core_refresh_done[0] = 1'b0;
        refresh_strobe[0] = 1'b0;
        #1;
        check_eq("refresh2_exit", 64'(core_refresh[0]), 64'd0);
        @(negedge clk); #1;
        check_eq("refresh3_start", 64'(core_refresh[0]), 64'd1);
        core_refresh_done[0] = 1'b1;
        @(negedge clk);
        core_refresh_done[0] = 1'b0;
        #1;
        check_eq("refresh3_exit", 64'(core_refresh[0]), 64'd0);

        // Lock: ch2 holds the port for three accesses; ch1 and refresh wait.
        load_channels(0);
        ch_algn[0] = 4'b0100;
        ch_req[0]  = 4'b0100;
        exp_q.push_back(OW'(2));
        @(negedge clk); #1;
        wait_issue(0);
        grant_and_ack(0, 1, 1'b0, 4'b1111, 4'b0000);
        check_eq("lock_enter", 64'(ch_algn_ack[0]), 64'b0100);
        ch_req[0][1] = 1'b1;
        refresh_strobe[0] = 1'b1;
        @(negedge clk);
        refresh_strobe[0] = 1'b0;
        #1;
        for (int n = 0; n < 2; n++) begin
            exp_q.push_back(OW'(2));
            wait_issue(0);
            keep_v = (n == 1) ? 4'b1011 : 4'b1111;
            grant_and_ack(0, $urandom_range(0, 2), 1'b0, keep_v, 4'b0100);
            check_eq("lock_held", 64'(ch_algn_ack[0]), 64'b0100);
        end
        @(negedge clk); #1;
        check_eq("lock_wait_req", 64'(core_req[0]), 64'd0);
        check_eq("lock_wait_refresh", 64'(core_refresh[0]), 64'd0);
        check_eq("lock_wait_algn", 64'(ch_algn_ack[0]), 64'b0100);
        ch_algn[0] = 4'b0000;
        @(negedge clk); #1;
        check_eq("unlock_algn_ack", 64'(ch_algn_ack[0]), 64'd0);
        check_eq("unlock_idle_refresh", 64'(core_refresh[0]), 64'd0);
        check_eq("unlock_idle_req", 64'(core_req[0]), 64'd0);
        @(negedge clk); #1;
        check_eq("unlock_refresh", 64'(core_refresh[0]), 64'd1);
        core_refresh_done[0] = 1'b1;
        @(negedge clk);
        core_refresh_done[0] = 1'b0;
        #1;
        exp_q.push_back(OW'(1));
        @(negedge clk); #1;
        check_eq("ch1_after_lock", 64'(core_req[0]), 64'd1);
        grant_and_ack(0, 0, 1'b0, 4'b0000, 4'b0000);

        // Reset mid-ISSUE (fixed) and mid-REFRESH (round-robin), with an ack racing it.
        ch_req[0] = 4'b1010;
        refresh_strobe[1] = 1'b1;
        @(negedge clk);
        refresh_strobe[1] = 1'b0;
        #1;
        check_eq("pre_rst_req", 64'(core_req[0]), 64'd1);
        check_eq("pre_rst_refresh", 64'(core_refresh[1]), 64'd1);
        core_ack[0] = 1'b1;
        rst = 1'b1;
        last_owner[0] = NCH - 1;
        last_owner[1] = NCH - 1;
        #1;
        check_eq("async_rst_req", 64'(core_req[0]), 64'd0);
        check_eq("async_rst_ack", 64'(ch_ack[0]), 64'd0);
        check_eq("async_rst_refresh", 64'(core_refresh[1]), 64'd0);
        check_eq("async_rst_owner", 64'(owner[0]), 64'd0);
        check_eq("async_rst_addr", 64'(core_address[0]), 64'd0);
        core_ack[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ch_req[1] = 4'b1111;
        exp_q.push_back(OW'(1));
        @(negedge clk); #1;
        check_eq("post_rst_latency", 64'(core_req[0]), 64'd1);
        grant_and_ack(0, 1, 1'b0, 4'b0000, 4'b0000);
        exp_q.push_back(OW'(0));
        wait_issue(1);
        grant_and_ack(1, 0, 1'b0, 4'b0000, 4'b0000);

        // core_ack / core_refresh_done while idle have no effect.
        @(negedge clk);
        core_ack[0] = 1'b1;
        core_refresh_done[0] = 1'b1;
        #1;
        check_eq("idle_ack_ignored", 64'(ch_ack[0]), 64'd0);
        @(negedge clk);
        core_ack[0] = 1'b0;
        core_refresh_done[0] = 1'b0;
        #1;
        check_eq("idle_stays_req", 64'(core_req[0]), 64'd0);
        check_eq("idle_stays_refresh", 64'(core_refresh[0]), 64'd0);
        check_eq("exp_q_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
